// File: rtl/prco_fetch_if.sv
// ============================================================================
//  Module      : prco_fetch_if
//  Description : Fetch-unit bundle: enable/stall/redirect control, local
//                memory fetch port and decode-side instruction handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prco_fetch_if;
  logic        i_en;
  logic        i_stall;
  logic        i_branch;
  logic [15:0] i_branch_addr;
  logic        q_ce_fetch;
  logic [15:0] q_fetch_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_data;
  logic [15:0] q_instr;
  logic [15:0] q_pc;
  logic        q_valid;
  logic        i_dec_ready;
  logic        q_err;
  logic [15:0] q_fetch_count;

  modport master (
    input  i_en, i_stall, i_branch, i_branch_addr,
    input  i_mem_ack, i_mem_data, i_dec_ready,
    output q_ce_fetch, q_fetch_addr, q_instr, q_pc, q_valid, q_err, q_fetch_count
  );

  modport slave (
    output i_en, i_stall, i_branch, i_branch_addr,
    output i_mem_ack, i_mem_data, i_dec_ready,
    input  q_ce_fetch, q_fetch_addr, q_instr, q_pc, q_valid, q_err, q_fetch_count
  );
endinterface

`default_nettype wire

// File: rtl/prco_fetch.sv
// ============================================================================
//  Module      : prco_fetch
//  Description : Instruction fetch FSM: strobes local memory, captures the
//                returned word and holds it until decode accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prco_fetch #(
  parameter logic [15:0] P_RESET_PC    = 16'h0000,
  parameter logic [15:0] P_PC_MAX      = 16'h00FF,
  parameter int          P_ACK_TIMEOUT = 4
) (
  input  wire logic     i_clk,
  input  wire logic     i_reset,
  prco_fetch_if.master  bus
);

  localparam int C_TMO_W = (P_ACK_TIMEOUT > 2) ? $clog2(P_ACK_TIMEOUT) : 1;
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(P_ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t             r_state;
  logic [15:0]        r_pc;
  logic               r_kill;
  logic [C_TMO_W-1:0] r_tmo;
  logic               r_ce_fetch;
  logic [15:0]        r_fetch_addr;
  logic [15:0]        r_instr;
  logic [15:0]        r_instr_pc;
  logic               r_valid;
  logic               r_err;
  logic [15:0]        r_fetch_count;

  logic               w_go;
  logic [15:0]        w_target;
  logic [15:0]        w_pc_inc;

  assign w_go     = bus.i_en & ~bus.i_stall;
  // A redirect wins over the current PC wherever the next address is chosen.
  assign w_target = bus.i_branch ? bus.i_branch_addr : r_pc;
  assign w_pc_inc = (r_pc == P_PC_MAX) ? 16'h0000 : r_pc + 16'd1;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= P_RESET_PC;
      r_kill        <= 1'b0;
      r_tmo         <= '0;
      r_ce_fetch    <= 1'b0;
      r_fetch_addr  <= P_RESET_PC;
      r_instr       <= 16'h0000;
      r_instr_pc    <= 16'h0000;
      r_valid       <= 1'b0;
      r_err         <= 1'b0;
      r_fetch_count <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pc <= w_target;
          if (w_go) begin
            r_ce_fetch   <= 1'b1;
            r_fetch_addr <= w_target;
            r_state      <= ST_REQ;
          end
        end

        ST_REQ: begin
          // The strobe is already out; a redirect here must orphan its reply.
          r_ce_fetch <= 1'b0;
          r_tmo      <= '0;
          r_state    <= ST_WAIT;
          if (bus.i_branch) begin
            r_pc   <= bus.i_branch_addr;
            r_kill <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (bus.i_mem_ack) begin
            if (r_kill || bus.i_branch) begin
              r_pc         <= w_target;
              r_kill       <= 1'b0;
              r_ce_fetch   <= 1'b1;
              r_fetch_addr <= w_target;
              r_state      <= ST_REQ;
            end else begin
              r_instr    <= bus.i_mem_data;
              r_instr_pc <= r_pc;
              r_valid    <= 1'b1;
              r_pc       <= w_pc_inc;
              r_state    <= ST_HOLD;
            end
          end else if (r_tmo == C_TMO_LAST) begin
            r_err   <= 1'b1;
            r_kill  <= 1'b0;
            r_pc    <= w_target;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + C_TMO_W'(1);
            if (bus.i_branch) begin
              r_pc   <= bus.i_branch_addr;
              r_kill <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (bus.i_branch || bus.i_dec_ready) begin
            r_valid <= 1'b0;
            r_pc    <= w_target;
            if (!bus.i_branch) begin
              r_fetch_count <= r_fetch_count + 16'd1;
            end
            if (w_go) begin
              r_ce_fetch   <= 1'b1;
              r_fetch_addr <= w_target;
              r_state      <= ST_REQ;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.q_ce_fetch    = r_ce_fetch;
  assign bus.q_fetch_addr  = r_fetch_addr;
  assign bus.q_instr       = r_instr;
  assign bus.q_pc          = r_instr_pc;
  assign bus.q_valid       = r_valid;
  assign bus.q_err         = r_err;
  assign bus.q_fetch_count = r_fetch_count;

endmodule

`default_nettype wire
